// File: rtl/rv32im_dmem_resp.sv
// Data-memory responder for the LSU<->DMEM interface: one outstanding request,
// byte/halfword/word access to a word-organised RAM, programmable wait states.
module rv32im_dmem_resp #(
  parameter int unsigned               API_ADDR_WIDTH  = 32,
  parameter int unsigned               API_DATA_WIDTH  = 32,
  parameter int unsigned               MEM_DEPTH_WORDS = 1024,
  parameter logic [API_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned               WAIT_CYCLES     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu2dmem_req_i,
  input  logic                      lsu2dmem_cmd_i,
  input  logic [2:0]                lsu2dmem_width_i,
  input  logic [API_ADDR_WIDTH-1:0] lsu2dmem_addr_i,
  input  logic [API_DATA_WIDTH-1:0] lsu2dmem_wdata_i,
  output logic                      dmem2lsu_req_ack_o,
  output logic [API_DATA_WIDTH-1:0] dmem2lsu_rdata_o,
  output logic [1:0]                dmem2lsu_respone_o
);

  localparam logic [2:0] MEM_WIDTH_BYTE  = 3'b000;
  localparam logic [2:0] MEM_WIDTH_HWORD = 3'b001;
  localparam logic [2:0] MEM_WIDTH_WORD  = 3'b010;
  localparam logic [1:0] MEM_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] MEM_RESP_RDY_OK = 2'b01;
  localparam logic [1:0] MEM_RESP_RDY_ER = 2'b10;

  localparam int unsigned IDXW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

  // Range bounds are one bit wider so BASE_ADDR + size cannot wrap.
  localparam logic [API_ADDR_WIDTH:0] C_BASE  = {1'b0, BASE_ADDR};
  localparam logic [API_ADDR_WIDTH:0] C_SPAN  = (API_ADDR_WIDTH + 1)'(4 * MEM_DEPTH_WORDS);
  localparam logic [API_ADDR_WIDTH:0] C_LIMIT = C_BASE + C_SPAN;
  localparam logic [3:0] C_CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_ack;
  logic [3:0]                r_cnt;
  logic                      r_cmd;
  logic [2:0]                r_width;
  logic [1:0]                r_lane;
  logic [IDXW-1:0]           r_idx;
  logic [API_DATA_WIDTH-1:0] r_wdata;
  logic                      r_err;

  logic [API_ADDR_WIDTH:0]   w_addr_ext;
  logic [API_ADDR_WIDTH-1:0] w_off;
  logic                      w_err;
  logic                      w_unused_off;

  logic [31:0]               r_mem [MEM_DEPTH_WORDS];
  logic                      w_we;
  logic [3:0]                w_be;
  logic [31:0]               w_wsh;
  logic [31:0]               w_rsh;
  logic [API_DATA_WIDTH-1:0] w_rdata;
  logic [1:0]                w_resp;

  assign w_addr_ext   = {1'b0, lsu2dmem_addr_i};
  assign w_off        = lsu2dmem_addr_i - BASE_ADDR;
  assign w_unused_off = ^w_off[API_ADDR_WIDTH-1:IDXW+2];

  always_comb begin
    w_err = 1'b0;
    if ((w_addr_ext < C_BASE) || (w_addr_ext >= C_LIMIT)) w_err = 1'b1;
    case (lsu2dmem_width_i)
      MEM_WIDTH_BYTE:  ;
      MEM_WIDTH_HWORD: if (lsu2dmem_addr_i[0]) w_err = 1'b1;
      MEM_WIDTH_WORD:  if (lsu2dmem_addr_i[1:0] != 2'b00) w_err = 1'b1;
      default:         w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ack = lsu2dmem_req_i & ~rst;
        if (w_ack) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_cmd   <= 1'b0;
      r_width <= '0;
      r_lane  <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_ack) begin
      r_cnt   <= C_CNT_INIT;
      r_cmd   <= lsu2dmem_cmd_i;
      r_width <= lsu2dmem_width_i;
      r_lane  <= lsu2dmem_addr_i[1:0];
      r_idx   <= w_off[IDXW+1:2];
      r_wdata <= lsu2dmem_wdata_i;
      r_err   <= w_err;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Store data arrives right-aligned; shift it onto the addressed lanes.
  always_comb begin
    case (r_width)
      MEM_WIDTH_BYTE:  w_be = 4'b0001 << r_lane;
      MEM_WIDTH_HWORD: w_be = 4'b0011 << r_lane;
      MEM_WIDTH_WORD:  w_be = 4'b1111;
      default:         w_be = 4'b0000;
    endcase
  end

  assign w_wsh = r_wdata << {r_lane, 3'b000};
  assign w_we  = (r_state == S_RESP) & ~r_err & r_cmd & ~rst;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wsh[8*i +: 8];
      end
    end
  end

  assign w_rsh = r_mem[r_idx] >> {r_lane, 3'b000};

  always_comb begin
    w_rdata = '0;
    w_resp  = MEM_RESP_NOTRDY;
    if (r_state == S_RESP) begin
      w_resp = r_err ? MEM_RESP_RDY_ER : MEM_RESP_RDY_OK;
      if (!r_err && !r_cmd) begin
        case (r_width)
          MEM_WIDTH_BYTE:  w_rdata = {24'b0, w_rsh[7:0]};
          MEM_WIDTH_HWORD: w_rdata = {16'b0, w_rsh[15:0]};
          MEM_WIDTH_WORD:  w_rdata = w_rsh;
          default:         w_rdata = '0;
        endcase
      end
    end
  end

  assign dmem2lsu_req_ack_o = w_ack;
  assign dmem2lsu_rdata_o   = w_rdata;
  assign dmem2lsu_respone_o = w_resp;

endmodule

// File: tb/tb_rv32im_dmem_resp.sv
// Directed bench for rv32im_dmem_resp: vector table on a WAIT_CYCLES=1 instance,
// plus latency, held-request and reset-abort sequences across 0/1/3 wait states.
module tb_rv32im_dmem_resp;

  localparam logic [2:0] WB   = 3'b000;
  localparam logic [2:0] WH   = 3'b001;
  localparam logic [2:0] WW   = 3'b010;
  localparam logic [1:0] R_OK = 2'b01;
  localparam logic [1:0] R_ER = 2'b10;
  localparam int NV = 18;

  typedef struct {
    logic        cmd;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        cmd;
  logic [2:0]  width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack0, ack1, ack3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic [1:0]  resp0, resp1, resp3;

  int total = 0;
  int bad   = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  rv32im_dmem_resp #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .lsu2dmem_req_i(req), .lsu2dmem_cmd_i(cmd),
    .lsu2dmem_width_i(width), .lsu2dmem_addr_i(addr), .lsu2dmem_wdata_i(wdata),
    .dmem2lsu_req_ack_o(ack0), .dmem2lsu_rdata_o(rdata0), .dmem2lsu_respone_o(resp0)
  );

  rv32im_dmem_resp #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .lsu2dmem_req_i(req), .lsu2dmem_cmd_i(cmd),
    .lsu2dmem_width_i(width), .lsu2dmem_addr_i(addr), .lsu2dmem_wdata_i(wdata),
    .dmem2lsu_req_ack_o(ack1), .dmem2lsu_rdata_o(rdata1), .dmem2lsu_respone_o(resp1)
  );

  rv32im_dmem_resp #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .lsu2dmem_req_i(req), .lsu2dmem_cmd_i(cmd),
    .lsu2dmem_width_i(width), .lsu2dmem_addr_i(addr), .lsu2dmem_wdata_i(wdata),
    .dmem2lsu_req_ack_o(ack3), .dmem2lsu_rdata_o(rdata3), .dmem2lsu_respone_o(resp3)
  );

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction on dut1; req stays high through WAIT to show it is ignored.
  task automatic do_txn(input logic c, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d, input string nm,
                        output logic [31:0] rd, output logic [1:0] rs, output int lat);
    int n;
    bit got;
    @(negedge clk);
    req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
    #1;
    n = 0;
    while (!ack1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check32({nm, "_ack"}, 32'(ack1), 32'd1);
    @(posedge clk);
    rd = '0; rs = 2'b00; lat = -1; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check32({nm, "_ack_one_cycle"}, 32'(ack1), 32'd0);
      if (resp1 != 2'b00) begin
        got = 1'b1; lat = k; rd = rdata1; rs = resp1;
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;
    int          l0, l3;
    int          at [3][5];
    int          na [3];

    vecs[0]  = '{1'b1, WW, 32'h0000_0010, 32'hDEADBEEF, R_OK, 32'h0};
    vecs[1]  = '{1'b0, WW, 32'h0000_0010, 32'h0,        R_OK, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, WW, 32'h0000_0004, 32'h11223344, R_OK, 32'h0};
    vecs[3]  = '{1'b1, WB, 32'h0000_0007, 32'hFFFFFFAA, R_OK, 32'h0};
    vecs[4]  = '{1'b0, WW, 32'h0000_0004, 32'h0,        R_OK, 32'hAA223344};
    vecs[5]  = '{1'b0, WB, 32'h0000_0005, 32'h0,        R_OK, 32'h00000033};
    vecs[6]  = '{1'b0, WH, 32'h0000_0006, 32'h0,        R_OK, 32'h0000AA22};
    vecs[7]  = '{1'b0, WW, 32'h0000_0002, 32'h0,        R_ER, 32'h0};
    vecs[8]  = '{1'b1, WW, 32'h0000_0FFC, 32'h0BADF00D, R_OK, 32'h0};
    vecs[9]  = '{1'b1, WW, 32'h0000_1000, 32'h12345678, R_ER, 32'h0};
    vecs[10] = '{1'b0, WW, 32'h0000_0FFC, 32'h0,        R_OK, 32'h0BADF00D};
    vecs[11] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,    R_ER, 32'h0};
    vecs[12] = '{1'b1, WH, 32'h0000_0012, 32'hFFFFCAFE, R_OK, 32'h0};
    vecs[13] = '{1'b0, WW, 32'h0000_0010, 32'h0,        R_OK, 32'hCAFEBEEF};
    vecs[14] = '{1'b1, WH, 32'h0000_0011, 32'h00001234, R_ER, 32'h0};
    vecs[15] = '{1'b0, WW, 32'h0000_0010, 32'h0,        R_OK, 32'hCAFEBEEF};
    vecs[16] = '{1'b0, WB, 32'h0000_0013, 32'h0,        R_OK, 32'h000000CA};
    vecs[17] = '{1'b1, WW, 32'h0000_0020, 32'h0,        R_OK, 32'h0};

    rst = 1'b1; req = 1'b1; cmd = 1'b0; width = WW; addr = 32'h10; wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check32("reset_ack", 32'(ack1), 32'd0);
    check32("reset_resp", 32'(resp1), 32'(2'b00));
    check32("reset_rdata", rdata1, 32'h0);
    rst = 1'b0; req = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i].cmd, vecs[i].width, vecs[i].addr, vecs[i].wdata,
             $sformatf("v%0d", i), rd, rs, lat);
      check32($sformatf("v%0d_resp", i), 32'(rs), 32'(vecs[i].exp_resp));
      check32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check32($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
    end

    // Reset while a word write sits in WAIT: nothing may reach the RAM.
    @(negedge clk);
    req = 1'b1; cmd = 1'b1; width = WW; addr = 32'h20; wdata = 32'h55555555;
    #1;
    check32("abort_ack", 32'(ack1), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check32("abort_ack_low", 32'(ack1), 32'd0);
    check32("abort_resp", 32'(resp1), 32'(2'b00));
    check32("abort_rdata", rdata1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    do_txn(1'b0, WW, 32'h20, 32'h0, "abort_read", rd, rs, lat);
    check32("abort_read_resp", 32'(rs), 32'(R_OK));
    check32("abort_read_rdata", rd, 32'h0);

    // Single request into all three instances at once.
    repeat (8) @(negedge clk);
    req = 1'b1; cmd = 1'b0; width = WW; addr = 32'h10;
    #1;
    check32("lat_ack_w0", 32'(ack0), 32'd1);
    check32("lat_ack_w3", 32'(ack3), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    l0 = -1; l3 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check32("w3_wait_resp", 32'(resp3), 32'(2'b00));
        check32("w3_wait_rdata", rdata3, 32'h0);
      end
      if (c == 2) check32("w0_idle_rdata", rdata0, 32'h0);
      if (l0 < 0 && resp0 != 2'b00) l0 = c;
      if (l3 < 0 && resp3 != 2'b00) l3 = c;
    end
    check32("lat_w0", 32'(l0), 32'd1);
    check32("lat_w3", 32'(l3), 32'd4);

    // Request held high: acceptances recur every WAIT_CYCLES+2 cycles.
    repeat (4) @(negedge clk);
    for (int j = 0; j < 3; j++) na[j] = 0;
    req = 1'b1; cmd = 1'b0; width = WW; addr = 32'h10;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (ack0 && na[0] < 5) begin at[0][na[0]] = c; na[0]++; end
      if (ack1 && na[1] < 5) begin at[1][na[1]] = c; na[1]++; end
      if (ack3 && na[2] < 5) begin at[2][na[2]] = c; na[2]++; end
      @(negedge clk);
    end
    req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check32($sformatf("hold_count_%0d", j), 32'(na[j] >= 3), 32'd1);
      if (na[j] >= 3) begin
        check32($sformatf("hold_first_%0d", j), 32'(at[j][0]), 32'd0);
        check32($sformatf("hold_gap1_%0d", j), 32'(at[j][1] - at[j][0]),
                (j == 0) ? 32'd2 : (j == 1) ? 32'd3 : 32'd5);
        check32($sformatf("hold_gap2_%0d", j), 32'(at[j][2] - at[j][1]),
                (j == 0) ? 32'd2 : (j == 1) ? 32'd3 : 32'd5);
      end
    end

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
